// File: rtl/trig_distributor.sv
// N-channel trigger fan-out: masked TRG pulses, synchronised ACK collection, timeout, veto hold.
// Optional per-channel miss counters are built when TRG_MISS_CNT_EN is defined.
module trig_distributor #(
  parameter int unsigned N_CH      = 12,
  parameter int unsigned MIN_W     = 4,
  parameter int unsigned TO_W      = 20,
  parameter int unsigned PULSE_LEN = 3,
  parameter int unsigned STAT_W    = 32
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [N_CH-1:0]     TRG_MASK,
  input  logic [MIN_W-1:0]    MIN_SCRODS_REQUIRED,
  input  logic [TO_W-1:0]     ACK_TIMEOUT,
  input  logic                TRG_SOFT,
  input  logic                TRG_EXT,
  input  logic                TRG_NEEDS_VETO,
  input  logic                TRG_FLOW_CTL_EN,
  input  logic                TRG_VETO_RESET,
  input  logic [N_CH-1:0]     ACK,
  output logic [N_CH-1:0]     TRG,
  output logic                BUSY,
  output logic [STAT_W-1:0]   TRG_COUNT,
  output logic [STAT_W-1:0]   TIMEOUT_COUNT,
  output logic [STAT_W-1:0]   DROP_COUNT,
  output logic [N_CH-1:0]     LAST_ACK_MASK,
  output logic [N_CH*8-1:0]   MISS_CNT
);

  localparam int unsigned PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  typedef enum logic [1:0] {StIdle, StFire, StWaitAck, StVeto} state_e;

  state_e              state_q, state_d;
  logic [N_CH-1:0]     ack_meta_q, ack_sync_q, ack_prev_q;
  logic                soft_q;
  logic [N_CH-1:0]     mask_l_q, mask_l_d;
  logic [N_CH-1:0]     ack_seen_q, ack_seen_d;
  logic [PW-1:0]       pulse_cnt_q, pulse_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [N_CH-1:0]     trg_q, trg_d;
  logic                busy_q, busy_d;
  logic [STAT_W-1:0]   trg_cnt_q, trg_cnt_d;
  logic [STAT_W-1:0]   to_count_q, to_count_d;
  logic [STAT_W-1:0]   drop_q, drop_d;
  logic [N_CH-1:0]     last_ack_q, last_ack_d;

  logic                req;
  logic [N_CH-1:0]     ack_edge;
  logic [N_CH-1:0]     ack_seen_upd;
  logic                done;
  logic                timeout;

  function automatic int unsigned popcount(input logic [N_CH-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < int'(N_CH); i++) c += 32'(v[i]);
    return c;
  endfunction

  assign req          = TRG_EXT | (TRG_SOFT & ~soft_q);
  assign ack_edge     = ack_sync_q & ~ack_prev_q;
  // Include ACK edges arriving this cycle so an exit never loses a same-cycle ACK.
  assign ack_seen_upd = ack_seen_q | (ack_edge & mask_l_q);
  assign done         = popcount(ack_seen_upd) >= 32'(MIN_SCRODS_REQUIRED);
  assign timeout      = (to_cnt_q == ACK_TIMEOUT);

  always_comb begin
    state_d     = state_q;
    mask_l_d    = mask_l_q;
    ack_seen_d  = ack_seen_q;
    pulse_cnt_d = pulse_cnt_q;
    to_cnt_d    = to_cnt_q;
    trg_d       = trg_q;
    trg_cnt_d   = trg_cnt_q;
    to_count_d  = to_count_q;
    drop_d      = drop_q;
    last_ack_d  = last_ack_q;

    if (req && (state_q != StIdle)) drop_d = drop_q + STAT_W'(1);

    unique case (state_q)
      StIdle: begin
        if (req && (TRG_MASK != '0)) begin
          mask_l_d    = TRG_MASK;
          ack_seen_d  = '0;
          trg_d       = TRG_MASK;
          trg_cnt_d   = trg_cnt_q + STAT_W'(1);
          pulse_cnt_d = '0;
          state_d     = StFire;
        end
      end
      StFire: begin
        ack_seen_d = ack_seen_upd;
        if (pulse_cnt_q == PW'(PULSE_LEN - 1)) begin
          trg_d    = '0;
          to_cnt_d = '0;
          state_d  = StWaitAck;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PW'(1);
        end
      end
      StWaitAck: begin
        ack_seen_d = ack_seen_upd;
        if (done || timeout) begin
          last_ack_d = ack_seen_upd;
          if (!done) to_count_d = to_count_q + STAT_W'(1);
          state_d = (TRG_NEEDS_VETO && TRG_FLOW_CTL_EN) ? StVeto : StIdle;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      StVeto: begin
        if (!TRG_FLOW_CTL_EN || TRG_VETO_RESET) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      ack_meta_q  <= '0;
      ack_sync_q  <= '0;
      ack_prev_q  <= '0;
      soft_q      <= 1'b0;
      mask_l_q    <= '0;
      ack_seen_q  <= '0;
      pulse_cnt_q <= '0;
      to_cnt_q    <= '0;
      trg_q       <= '0;
      busy_q      <= 1'b0;
      trg_cnt_q   <= '0;
      to_count_q  <= '0;
      drop_q      <= '0;
      last_ack_q  <= '0;
    end else begin
      state_q     <= state_d;
      ack_meta_q  <= ACK;
      ack_sync_q  <= ack_meta_q;
      ack_prev_q  <= ack_sync_q;
      soft_q      <= TRG_SOFT;
      mask_l_q    <= mask_l_d;
      ack_seen_q  <= ack_seen_d;
      pulse_cnt_q <= pulse_cnt_d;
      to_cnt_q    <= to_cnt_d;
      trg_q       <= trg_d;
      busy_q      <= busy_d;
      trg_cnt_q   <= trg_cnt_d;
      to_count_q  <= to_count_d;
      drop_q      <= drop_d;
      last_ack_q  <= last_ack_d;
    end
  end

  assign TRG           = trg_q;
  assign BUSY          = busy_q;
  assign TRG_COUNT     = trg_cnt_q;
  assign TIMEOUT_COUNT = to_count_q;
  assign DROP_COUNT    = drop_q;
  assign LAST_ACK_MASK = last_ack_q;

`ifdef TRG_MISS_CNT_EN
  logic [N_CH*8-1:0] miss_q, miss_d;
  logic              exit_wait;

  assign exit_wait = (state_q == StWaitAck) && (done || timeout);

  always_comb begin
    miss_d = miss_q;
    if (exit_wait) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        if (mask_l_q[i] && !ack_seen_upd[i] && (miss_q[8*i +: 8] != 8'hFF)) begin
          miss_d[8*i +: 8] = miss_q[8*i +: 8] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) miss_q <= '0;
    else          miss_q <= miss_d;
  end

  assign MISS_CNT = miss_q;
`else
  assign MISS_CNT = '0;
`endif

endmodule
